// File: rtl/div_if.sv
// Divider request/response bundle between the E stage and div_ctrl.
interface div_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             signed_div;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             flush;
   logic             stall_div;
   logic             result_valid;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;

   modport master (
      output start, signed_div, a, b, flush,
      input  stall_div, result_valid, hi_o, lo_o
   );

   modport slave (
      input  start, signed_div, a, b, flush,
      output stall_div, result_valid, hi_o, lo_o
   );
endinterface

// File: rtl/div_ctrl.sv
// Iterative radix-2 restoring divider for MIPS DIV/DIVU in the E stage.
// Holds the pipeline via stall_div and strobes HI/LO for one cycle.
module div_ctrl #(
   parameter int WIDTH = 32
) (
   input  logic  clk,
   input  logic  rst,
   div_if.slave  bus
);
   localparam int CW = $clog2(WIDTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic             sq_q, sq_d;
   logic             sr_q, sr_d;

   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   logic [WIDTH:0]   t;
   logic [WIDTH:0]   diff;
   logic             ge;

   // r stays below |b| after every step, so its 33rd bit is always
   // zero and only the low WIDTH bits are stored.
   always_comb begin
      a_abs = (bus.signed_div & bus.a[WIDTH-1]) ? -bus.a : bus.a;
      b_abs = (bus.signed_div & bus.b[WIDTH-1]) ? -bus.b : bus.b;
      t     = {r_q, q_q[WIDTH-1]};
      diff  = t - {1'b0, b_q};
      ge    = (t >= {1'b0, b_q});

      state_d = state_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      q_d     = q_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      sq_d    = sq_q;
      sr_d    = sr_q;

      unique case (1'b1)
         (state_q == S_IDLE): begin
            if (bus.start && !bus.flush) begin
               b_d   = b_abs;
               q_d   = a_abs;
               r_d   = '0;
               cnt_d = '0;
               sq_d  = bus.signed_div &
                       (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
               sr_d  = bus.signed_div & bus.a[WIDTH-1];
               if (bus.b == '0) begin
                  hi_d    = bus.a;
                  lo_d    = '1;
                  state_d = S_DONE;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         (state_q == S_CALC): begin
            if (bus.flush) begin
               state_d = S_IDLE;
            end else begin
               r_d   = ge ? diff[WIDTH-1:0] : t[WIDTH-1:0];
               q_d   = {q_q[WIDTH-2:0], ge};
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CW'(WIDTH-1)) begin
                  state_d = S_DONE;
                  lo_d    = sq_q ? -q_d : q_d;
                  hi_d    = sr_q ? -r_d : r_d;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         r_q     <= '0;
         q_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         sq_q    <= 1'b0;
         sr_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         r_q     <= r_d;
         q_q     <= q_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         sq_q    <= sq_d;
         sr_q    <= sr_d;
      end
   end

   assign bus.stall_div =
      ((state_q == S_IDLE) & bus.start & ~bus.flush) |
      ((state_q == S_CALC) & ~bus.flush);
   assign bus.result_valid = (state_q == S_DONE) & ~bus.flush;
   assign bus.hi_o = hi_q;
   assign bus.lo_o = lo_q;
endmodule
